// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, buffers fetched words with their PCs in a
// small FIFO for decode, handles redirects and halts on the branch-to-self word.
// Optional `FETCH_STEP_EN adds a `step` input that gates fetch to one per rising edge.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] HALT_WORD = 32'hEAFF_FFFE,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef FETCH_STEP_EN
    input  logic             step,
`endif
    input  logic             start,
    input  logic             stop,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rd,
    output logic [31:0]      instr_out,
    output logic [31:0]      instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_t      state;
    logic [31:0] pc;
    entry_t      fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;

    logic pop, push, step_req, hit_halt, slot_free;

    assign pop       = instr_valid & instr_ready;
    // A full FIFO can still accept a push when the head is leaving this cycle.
    assign slot_free = (count < CNT_MAX) | pop;
    assign push      = (state == RUN) & ~stop & ~redirect & slot_free & step_req;
    assign hit_halt  = push & (imem_rd == HALT_WORD);

`ifdef FETCH_STEP_EN
    logic step_q, step_pend;
    assign step_req = (step & ~step_q) | step_pend;

    // An edge that cannot be served yet (FIFO full, not RUN) waits here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q <= step;
            if (redirect) step_pend <= 1'b0;
            else          step_pend <= step_req & ~push;
        end
    end
`else
    assign step_req = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            if (push && fetch_count != '1)
                fetch_count <= fetch_count + CNT_W'(1);
            if (redirect) begin
                state <= RUN;
                pc    <= {redirect_pc[31:2], 2'b00};
            end else begin
                case (state)
                    IDLE: if (start && !stop) state <= RUN;
                    RUN: begin
                        if (stop)          state <= IDLE;
                        else if (hit_halt) state <= HALT;
                        else if (push)     pc    <= pc + 32'd4;
                    end
                    HALT:    ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Redirect flushes everything, including an entry popped in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{word: imem_rd, pc: pc};
    end

    assign imem_addr   = pc;
    assign instr_valid = (count != '0);
    assign instr_out   = instr_valid ? fifo_mem[rd_ptr].word : 32'h0;
    assign instr_pc    = instr_valid ? fifo_mem[rd_ptr].pc   : 32'h0;
    assign halted      = (state == HALT);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, reset/step sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_sequencer;
    localparam int          DEPTH = 2;
    localparam int          CNT_W = 4;
    localparam logic [31:0] HW    = 32'hEAFF_FFFE;
    localparam logic [31:0] W0 = 32'hE3A0_2031, W1 = 32'hE3A0_30E6, W2 = 32'hE022_2003;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic instr_ready = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr, imem_rd, instr_out, instr_pc;
    logic instr_valid, halted;
    logic [CNT_W-1:0] fetch_count;
`ifdef FETCH_STEP_EN
    logic step = 1'b0;
`endif

    logic [31:0] imem [256];
    assign imem_rd = imem[imem_addr[9:2]];

    always #5 clk = ~clk;

    fetch_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
`ifdef FETCH_STEP_EN
        .step(step),
`endif
        .start(start), .stop(stop), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted), .fetch_count(fetch_count)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO as a queue, mode 0=idle 1=run 2=halt.
    typedef struct { logic [31:0] w; logic [31:0] a; } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;
    int          mmode, mcnt;

    task automatic model_reset;
        mq.delete();
        mpc = 32'h0; mmode = 0; mcnt = 0;
    endtask

    task automatic model_step;
        bit   pop, fetch;
        ent_t e;
        pop = (mq.size() > 0) && instr_ready;
        if (redirect) begin
            mq.delete();
            mpc   = redirect_pc & ~32'h3;
            mmode = 1;
        end else begin
            fetch = (mmode == 1) && !stop && (mq.size() < DEPTH || pop);
            if (pop) void'(mq.pop_front());
            if (fetch) begin
                e.w = imem[mpc[9:2]];
                e.a = mpc;
                mq.push_back(e);
                if (mcnt < (1 << CNT_W) - 1) mcnt++;
                if (e.w == HW) mmode = 2;
                else           mpc   = mpc + 32'd4;
            end
            if (mmode == 0 && start && !stop) mmode = 1;
            else if (mmode == 1 && stop)      mmode = 0;
        end
    endtask

    task automatic model_check;
        bit v;
        v = mq.size() > 0;
        chk("rnd_valid", {31'b0, instr_valid}, {31'b0, v});
        chk("rnd_out",   instr_out, v ? mq[0].w : 32'h0);
        chk("rnd_pc",    instr_pc,  v ? mq[0].a : 32'h0);
        chk("rnd_addr",  imem_addr, mpc);
        chk("rnd_halted", {31'b0, halted}, {31'b0, mmode == 2});
        chk("rnd_count", 32'(fetch_count), 32'(mcnt));
    endtask

    typedef struct {
        logic start, stop, ready, redir; logic [31:0] rpc;
        logic valid; logic [31:0] out, pc, addr; logic halt; int cnt;
    } vec_t;
    vec_t tbl[16];

    task automatic check_reset(input string tag);
        chk({tag, "_valid"},  {31'b0, instr_valid}, 32'h0);
        chk({tag, "_addr"},   imem_addr, 32'h0);
        chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
        chk({tag, "_count"},  32'(fetch_count), 32'h0);
        chk({tag, "_out"},    instr_out, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'hE3A0_0000 | 32'(i);
        imem[0] = W0; imem[1] = W1; imem[2] = W2; imem[3] = HW;

        repeat (2) cyc();
        check_reset("reset");
        reset_n = 1'b1;

`ifdef FETCH_STEP_EN
        // Three step pulses, the middle one held for 5 cycles.
        instr_ready = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        step = 1'b1; cyc(); step = 1'b0; cyc(); cyc();
        step = 1'b1; repeat (5) cyc(); step = 1'b0; cyc(); cyc();
        step = 1'b1; cyc(); step = 1'b0; repeat (4) cyc();
        chk("step_count", 32'(fetch_count), 32'd3);
        chk("step_addr",  imem_addr, 32'h0C);
        chk("step_valid", {31'b0, instr_valid}, 32'h0);
`else
        tbl[0]  = '{1,0,0,0,0, 0,0, 0,    0,    0,0};
        tbl[1]  = '{0,0,0,0,0, 1,W0,0,    4,    0,1};
        tbl[2]  = '{0,0,0,0,0, 1,W0,0,    8,    0,2};
        tbl[3]  = '{0,0,0,0,0, 1,W0,0,    8,    0,2};
        tbl[4]  = '{0,0,1,0,0, 1,W1,4,    'h0C, 0,3};
        tbl[5]  = '{0,0,1,0,0, 1,W2,8,    'h0C, 1,4};
        tbl[6]  = '{0,0,1,0,0, 1,HW,'h0C, 'h0C, 1,4};
        tbl[7]  = '{0,0,0,1,6, 0,0, 0,    4,    0,4};
        tbl[8]  = '{0,0,0,0,0, 1,W1,4,    8,    0,5};
        tbl[9]  = '{0,1,1,0,0, 0,0, 0,    8,    0,5};
        tbl[10] = '{1,1,1,0,0, 0,0, 0,    8,    0,5};
        tbl[11] = '{1,0,1,0,0, 0,0, 0,    8,    0,5};
        tbl[12] = '{0,0,1,0,0, 1,W2,8,    'h0C, 0,6};
        tbl[13] = '{0,0,1,0,0, 1,HW,'h0C, 'h0C, 1,7};
        tbl[14] = '{1,0,0,0,0, 1,HW,'h0C, 'h0C, 1,7};
        tbl[15] = '{0,0,1,0,0, 0,0, 0,    'h0C, 1,7};
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start; stop = tbl[i].stop; instr_ready = tbl[i].ready;
            redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
            cyc();
            chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].valid});
            chk($sformatf("vec%0d_out", i),   instr_out, tbl[i].out);
            chk($sformatf("vec%0d_pc", i),    instr_pc,  tbl[i].pc);
            chk($sformatf("vec%0d_addr", i),  imem_addr, tbl[i].addr);
            chk($sformatf("vec%0d_halted", i), {31'b0, halted}, {31'b0, tbl[i].halt});
            chk($sformatf("vec%0d_count", i), 32'(fetch_count), 32'(tbl[i].cnt));
        end
        start = 1'b0; stop = 1'b0; instr_ready = 1'b0;

        // Reset asserted mid-cycle while running with a full FIFO.
        redirect = 1'b1; redirect_pc = 32'h10; cyc();
        redirect = 1'b0; cyc(); cyc();
        chk("pre_reset_valid", {31'b0, instr_valid}, 32'h1);
        chk("pre_reset_pc",    instr_pc, 32'h10);
        #3 reset_n = 1'b0;
        #1 check_reset("async_reset");
        cyc();
        reset_n = 1'b1;

        // Randomized run: halt words sprinkled in, redirects to escape halt.
        for (int i = 0; i < 256; i++) imem[i] = ($urandom_range(0, 7) == 0) ? HW : ($urandom & 32'h7FFF_FFFF);
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            start       = ($urandom_range(0, 3) == 0);
            stop        = ($urandom_range(0, 15) == 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = $urandom_range(0, 1023);
            model_step();
            cyc();
            model_check();
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
